// File: rtl/mandel_pkg.sv
// Shared constants and state encoding for the Mandelbrot frame renderer.
package mandel_pkg;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned FRAC     = 28;
    localparam int unsigned H_RES    = 640;
    localparam int unsigned V_RES    = 480;
    localparam int unsigned MAX_ITER = 127;
    localparam int unsigned ADDR_W   = 19;
    localparam int unsigned CNT_W    = 7;

    localparam logic [WIDTH+1:0] ESCAPE_LIMIT = (WIDTH + 2)'(4) << FRAC;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StIter,
        StWrite,
        StDone
    } state_e;

endpackage

// File: rtl/mandel_iter_dp.sv
// One z = z^2 + c step plus the |z|^2 > 4 escape test, purely combinational.
module mandel_iter_dp
    import mandel_pkg::*;
#(
    parameter int unsigned Width = WIDTH,
    parameter int unsigned Frac  = FRAC
) (
    input  logic signed [Width-1:0] zr_i,
    input  logic signed [Width-1:0] zi_i,
    input  logic signed [Width-1:0] cr_i,
    input  logic signed [Width-1:0] ci_i,
    output logic signed [Width-1:0] next_zr_o,
    output logic signed [Width-1:0] next_zi_o,
    output logic                    escape_o
);

    localparam int unsigned PW = 2 * Width;
    localparam logic signed [Width+1:0] EscLimit = (Width + 2)'(4) << Frac;

    logic signed [PW-1:0]    zr_w, zi_w;
    logic signed [PW-1:0]    rr, ii, ri;
    logic signed [PW-1:0]    rr_s, ii_s, ri_s;
    logic signed [Width+1:0] mag;
    logic                    unused_hi;

    always_comb begin
        zr_w = PW'(zr_i);
        zi_w = PW'(zi_i);
        rr   = zr_w * zr_w;
        ii   = zi_w * zi_w;
        ri   = zr_w * zi_w;
        rr_s = rr >>> Frac;
        ii_s = ii >>> Frac;
        // Shifting one bit less folds the factor of two into the truncation.
        ri_s = ri >>> (Frac - 1);
        mag  = rr_s[Width+1:0] + ii_s[Width+1:0];

        escape_o  = mag > EscLimit;
        next_zr_o = rr_s[Width-1:0] - ii_s[Width-1:0] + cr_i;
        next_zi_o = ri_s[Width-1:0] + ci_i;
    end

    assign unused_hi = ^{rr_s[PW-1:Width+2], ii_s[PW-1:Width+2], ri_s[PW-1:Width]};

endmodule

// File: rtl/mandel_engine.sv
// Raster-scans the complex plane and writes one 7-bit escape count per pixel to the
// frame buffer write port; one frame per start pulse.
module mandel_engine #(
    parameter int unsigned WIDTH    = mandel_pkg::WIDTH,
    parameter int unsigned FRAC     = mandel_pkg::FRAC,
    parameter int unsigned H_RES    = mandel_pkg::H_RES,
    parameter int unsigned V_RES    = mandel_pkg::V_RES,
    parameter int unsigned MAX_ITER = mandel_pkg::MAX_ITER
) (
    input  logic             CLK_100MHz,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] cre_min,
    input  logic [WIDTH-1:0] cim_max,
    input  logic [WIDTH-1:0] step,
    output logic             busy,
    output logic             done,
    output logic             wea,
    output logic [18:0]      addr_w,
    output logic [6:0]       dina
);
    import mandel_pkg::*;

    localparam int unsigned XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int unsigned YW = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam logic [XW-1:0]    XLast = XW'(H_RES - 1);
    localparam logic [YW-1:0]    YLast = YW'(V_RES - 1);
    localparam logic [CNT_W-1:0] NMax  = CNT_W'(MAX_ITER);

    state_e                    state_q;
    logic                      busy_q, done_q, wea_q;
    logic [ADDR_W-1:0]         addr_w_q, addr_q;
    logic [CNT_W-1:0]          dina_q, n_q;
    logic [XW-1:0]             x_q;
    logic [YW-1:0]             y_q;
    logic signed [WIDTH-1:0]   zr_q, zi_q, cr_q, ci_q, cre_q, step_q;
    logic signed [WIDTH-1:0]   zr_d, zi_d;
    logic                      escape;

    mandel_iter_dp #(
        .Width (WIDTH),
        .Frac  (FRAC)
    ) u_iter_dp (
        .zr_i      (zr_q),
        .zi_i      (zi_q),
        .cr_i      (cr_q),
        .ci_i      (ci_q),
        .next_zr_o (zr_d),
        .next_zi_o (zi_d),
        .escape_o  (escape)
    );

    always_ff @(posedge CLK_100MHz or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wea_q    <= 1'b0;
            addr_w_q <= '0;
            dina_q   <= '0;
            addr_q   <= '0;
            n_q      <= '0;
            x_q      <= '0;
            y_q      <= '0;
            zr_q     <= '0;
            zi_q     <= '0;
            cr_q     <= '0;
            ci_q     <= '0;
            cre_q    <= '0;
            step_q   <= '0;
        end else begin
            done_q <= 1'b0;
            wea_q  <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        cre_q   <= cre_min;
                        step_q  <= step;
                        cr_q    <= cre_min;
                        ci_q    <= cim_max;
                        x_q     <= '0;
                        y_q     <= '0;
                        addr_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StInit;
                    end
                end
                StInit: begin
                    zr_q    <= '0;
                    zi_q    <= '0;
                    n_q     <= '0;
                    state_q <= StIter;
                end
                StIter: begin
                    if (escape || n_q == NMax) begin
                        wea_q    <= 1'b1;
                        addr_w_q <= addr_q;
                        dina_q   <= n_q;
                        state_q  <= StWrite;
                    end else begin
                        zr_q <= zr_d;
                        zi_q <= zi_d;
                        n_q  <= n_q + 1'b1;
                    end
                end
                StWrite: begin
                    if (x_q == XLast && y_q == YLast) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StDone;
                    end else begin
                        // Incremental stepping keeps the raster free of multipliers.
                        addr_q <= addr_q + 1'b1;
                        if (x_q == XLast) begin
                            x_q  <= '0;
                            y_q  <= y_q + 1'b1;
                            cr_q <= cre_q;
                            ci_q <= ci_q - step_q;
                        end else begin
                            x_q  <= x_q + 1'b1;
                            cr_q <= cr_q + step_q;
                        end
                        state_q <= StInit;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign wea    = wea_q;
    assign addr_w = addr_w_q;
    assign dina   = dina_q;

endmodule
